// File: rtl/macu_pkg.sv
// Shared definitions for the macu dot-product sequencer: FSM states,
// default datapath widths and the accumulator saturation helper.
package macu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam int DW_DEF = 8;
  localparam int CW_DEF = 16;

  // Clamp a sign-extended value into the signed range of a cw-bit accumulator.
  // cw is always a constant at the call site, so the bounds fold away.
  function automatic logic signed [31:0] sat_val(input logic signed [31:0] v,
                                                 input int cw);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (cw - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (cw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/macu.sv
// Pipelined signed multiply-accumulate unit.
// Slot issued in cycle t: xi/wi sampled at edge t+1, ci sampled during
// cycle t+2, co = x*w + ci visible during cycle t+4.
module macu import macu_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] xi,
  input  logic signed [DW-1:0] wi,
  input  logic                 w_en,
  input  logic signed [CW-1:0] ci,
  output logic signed [CW:0]   co
);

  logic signed [DW-1:0]   x_reg;
  logic signed [DW-1:0]   w_reg;
  logic signed [2*DW-1:0] prod_reg;
  logic signed [2*DW-1:0] prod_d_reg;
  logic signed [CW-1:0]   ci_reg;
  logic signed [CW:0]     co_reg;

  // Operand capture, product, alignment with ci, and final add.
  // The weight register only loads when w_en is set; bubbles carry x=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg      <= '0;
      w_reg      <= '0;
      prod_reg   <= '0;
      prod_d_reg <= '0;
      ci_reg     <= '0;
      co_reg     <= '0;
    end else begin
      x_reg <= xi;
      if (w_en) begin
        w_reg <= wi;
      end
      prod_reg   <= (2*DW)'(x_reg) * (2*DW)'(w_reg);
      prod_d_reg <= prod_reg;
      ci_reg     <= ci;
      co_reg     <= (CW+1)'(prod_d_reg) + (CW+1)'(ci_reg);
    end
  end

  assign co = co_reg;

endmodule

// File: rtl/macu_dot_seq.sv
// Dot-product sequencer around one macu. Even and odd issue slots build
// two independent partial sums through direct co->ci feedback so a pair can
// be accepted every cycle; DRAIN merges the two sums into out_data.
module macu_dot_seq import macu_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF,
  parameter int LW = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LW-1:0]        cfg_len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_x,
  input  logic signed [DW-1:0] in_w,
  output logic signed [DW-1:0] mac_xi,
  output logic signed [DW-1:0] mac_wi,
  output logic                 mac_w_en,
  output logic signed [CW-1:0] mac_ci,
  output logic signed [CW:0]   mac_co,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [CW:0]   out_data,
  output logic                 ovf
);

  state_t               state_reg;
  logic [LW-1:0]        cnt_reg;
  logic [LW-1:0]        len_reg;
  logic [1:0]           dcnt_reg;
  logic                 run_d1_reg;
  logic                 fb_reg;
  logic signed [CW-1:0] psum_a_reg;
  logic signed [CW:0]   out_data_reg;
  logic                 out_valid_reg;
  logic                 ovf_reg;

  logic                 accept;
  logic signed [31:0]   co_wide;
  logic signed [31:0]   co_sat_wide;
  logic signed [CW-1:0] co_sat;
  logic                 co_clamp;

  assign accept   = (state_reg == ST_RUN) && in_valid;
  assign busy     = (state_reg != ST_IDLE);
  assign in_ready = (state_reg == ST_RUN);

  // Issue: accepted pairs go straight to the macu, everything else is a
  // zero-product bubble that keeps the even/odd slot rhythm.
  assign mac_xi   = accept ? in_x : '0;
  assign mac_wi   = accept ? in_w : '0;
  assign mac_w_en = accept;

  // Saturated view of co; used both for feedback and for the final merge.
  assign co_wide     = 32'(mac_co);
  assign co_sat_wide = sat_val(co_wide, CW);
  assign co_sat      = co_sat_wide[CW-1:0];
  assign co_clamp    = (co_sat_wide != co_wide);

  // Feedback is unregistered so co of slot c-4 lands on ci of slot c-2.
  assign mac_ci = fb_reg ? co_sat : '0;

  macu #(
    .DW (DW),
    .CW (CW)
  ) u_macu (
    .clk   (clk),
    .rst_n (rst_n),
    .xi    (mac_xi),
    .wi    (mac_wi),
    .w_en  (mac_w_en),
    .ci    (mac_ci),
    .co    (mac_co)
  );

  // Feedback enable: a slot chains only if it was issued while in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_d1_reg <= 1'b0;
      fb_reg     <= 1'b0;
    end else begin
      run_d1_reg <= (state_reg == ST_RUN);
      fb_reg     <= run_d1_reg;
    end
  end

  // Job control FSM with registered result, valid and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      len_reg       <= '0;
      dcnt_reg      <= '0;
      psum_a_reg    <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            cnt_reg   <= '0;
            len_reg   <= cfg_len;
            state_reg <= (cfg_len != '0) ? ST_RUN : ST_DRAIN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            cnt_reg <= cnt_reg + LW'(1);
            if (cnt_reg + LW'(1) == len_reg) begin
              state_reg <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // d2 sees the final co of one parity, d3 the other.
          dcnt_reg <= dcnt_reg + 2'd1;
          if (dcnt_reg == 2'd2) begin
            psum_a_reg <= co_sat;
          end
          if (dcnt_reg == 2'd3) begin
            out_data_reg  <= (CW+1)'(psum_a_reg) + (CW+1)'(co_sat);
            out_valid_reg <= 1'b1;
            state_reg     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      // Sticky overflow: cleared by an accepted start, set by any clamp on
      // a co value that is fed back or merged.
      if ((state_reg == ST_IDLE) && start) begin
        ovf_reg <= 1'b0;
      end else if (co_clamp && (fb_reg || (state_reg == ST_DRAIN))) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_macu_dot_seq.sv
// Randomised and directed bench for macu_dot_seq. The reference model is a
// plain per-parity saturating accumulation over issue slots; expected
// control outputs follow the job timeline (start, LEN accepts, 4 drain
// cycles, result until accepted).
module tb_macu_dot_seq;

  localparam int DW = 8;
  localparam int CW = 16;
  localparam int LW = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [LW-1:0]        cfg_len = '0;
  logic                 busy;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_x = '0;
  logic signed [DW-1:0] in_w = '0;
  logic signed [DW-1:0] mac_xi;
  logic signed [DW-1:0] mac_wi;
  logic                 mac_w_en;
  logic signed [CW-1:0] mac_ci;
  logic signed [CW:0]   mac_co;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [CW:0]   out_data;
  logic                 ovf;

  macu_dot_seq #(.DW(DW), .CW(CW), .LW(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_len   (cfg_len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .mac_xi    (mac_xi),
    .mac_wi    (mac_wi),
    .mac_w_en  (mac_w_en),
    .mac_ci    (mac_ci),
    .mac_co    (mac_co),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle, maintained by the stimulus.
  bit     e_busy = 1'b0;
  bit     e_in_ready = 1'b0;
  bit     e_out_valid = 1'b0;
  bit     e_ovf = 1'b0;
  bit     chk_ovf = 1'b0;
  longint e_out_data = 0;

  // Job description: pairs by accept index, valid pattern by RUN cycle.
  int px[$];
  int pw[$];
  bit pv[$];

  longint model_out;
  bit     model_ovf;
  longint cap_out;
  bit     cap_ovf;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat_cw(input longint v, output bit hit);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (CW - 1)) - 1;
    lo = -(longint'(1) <<< (CW - 1));
    hit = (v > hi) || (v < lo);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison of DUT outputs against the expected timeline.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", longint'(busy), 0);
      chk("rst_in_ready", longint'(in_ready), 0);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_ovf", longint'(ovf), 0);
      chk("rst_out_data", longint'(out_data), 0);
      chk("rst_mac_xi", longint'(mac_xi), 0);
      chk("rst_mac_wi", longint'(mac_wi), 0);
      chk("rst_mac_ci", longint'(mac_ci), 0);
      chk("rst_mac_w_en", longint'(mac_w_en), 0);
    end else begin
      chk("busy", longint'(busy), longint'(e_busy));
      chk("in_ready", longint'(in_ready), longint'(e_in_ready));
      chk("out_valid", longint'(out_valid), longint'(e_out_valid));
      chk("mac_w_en", longint'(mac_w_en), longint'(e_in_ready && in_valid));
      chk("mac_xi", longint'(mac_xi), (e_in_ready && in_valid) ? longint'(in_x) : 64'sd0);
      chk("mac_wi", longint'(mac_wi), (e_in_ready && in_valid) ? longint'(in_w) : 64'sd0);
      if (!e_busy) chk("mac_ci_idle", longint'(mac_ci), 0);
      if (e_out_valid) chk("out_data", longint'(out_data), e_out_data);
      if (chk_ovf) chk("ovf", longint'(ovf), longint'(e_ovf));
    end
  end

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    e_busy = 1'b0;
    e_in_ready = 1'b0;
    e_out_valid = 1'b0;
    e_ovf = 1'b0;
    chk_ovf = 1'b1;
    repeat (cycles) step();
    rst_n = 1'b1;
  endtask

  // Runs one job starting in the current (IDLE) cycle. abort_at >= 0 pulls
  // rst_n low once that many pairs have been accepted.
  task automatic run_job(input int len, input int hold, input int abort_at);
    longint acc[2];
    bit     hit;
    int     n;
    int     slot;
    start = 1'b1;
    cfg_len = LW'(len);
    in_valid = 1'($urandom_range(1));
    in_x = DW'($urandom);
    in_w = DW'($urandom);
    e_busy = 1'b0;
    e_in_ready = 1'b0;
    e_out_valid = 1'b0;
    step();
    start = 1'b0;
    chk_ovf = 1'b0;
    acc[0] = 0;
    acc[1] = 0;
    model_ovf = 1'b0;
    n = 0;
    slot = 0;
    if (len > 0) begin
      e_busy = 1'b1;
      e_in_ready = 1'b1;
      while (n < len) begin
        if (n == abort_at) begin
          do_reset(3);
          return;
        end
        in_valid = (slot < pv.size()) ? pv[slot] : 1'b1;
        start = ($urandom_range(7) == 0);
        cfg_len = LW'($urandom);
        if (in_valid) begin
          in_x = DW'(px[n]);
          in_w = DW'(pw[n]);
          acc[slot % 2] = sat_cw(acc[slot % 2] + longint'(px[n]) * longint'(pw[n]), hit);
          model_ovf = model_ovf | hit;
          n++;
        end else begin
          in_x = DW'($urandom);
          in_w = DW'($urandom);
        end
        slot++;
        step();
      end
    end
    e_busy = 1'b1;
    e_in_ready = 1'b0;
    repeat (4) begin
      in_valid = 1'($urandom_range(1));
      start = ($urandom_range(3) == 0);
      step();
    end
    model_out = acc[0] + acc[1];
    e_out_valid = 1'b1;
    e_out_data = model_out;
    e_ovf = model_ovf;
    chk_ovf = 1'b1;
    cap_out = longint'(out_data);
    cap_ovf = ovf;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start = (h == 2);
      in_valid = 1'b1;
      step();
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    e_out_valid = 1'b0;
    e_busy = 1'b0;
    in_valid = 1'($urandom_range(1));
  endtask

  task automatic set_pairs(input int n, input int lo, input int hi);
    px.delete();
    pw.delete();
    for (int i = 0; i < n; i++) begin
      px.push_back($signed($urandom_range(hi - lo)) + lo);
      pw.push_back($signed($urandom_range(hi - lo)) + lo);
    end
  endtask

  initial begin
    do_reset(3);
    step();

    // LEN=1: partner partial sum is zero.
    px = '{3}; pw = '{-4}; pv.delete();
    run_job(1, 0, -1);
    chk("t1_model", model_out, -12);
    chk("t1_out", cap_out, -12);
    chk("t1_ovf", longint'(cap_ovf), 0);

    // LEN=4 with two bubbles after the second pair.
    px = '{1, 2, 3, 4}; pw = '{1, 2, 3, 4}; pv = '{1, 1, 0, 0, 1, 1};
    run_job(4, 1, -1);
    chk("t2_model", model_out, 30);
    chk("t2_out", cap_out, 30);

    // Saturation in both parities.
    px = '{-128, -128, -128, -128, -128, -128};
    pw = '{-128, -128, -128, -128, -128, -128};
    pv.delete();
    run_job(6, 0, -1);
    chk("t3_model", model_out, 65534);
    chk("t3_out", cap_out, 65534);
    chk("t3_ovf", longint'(cap_ovf), 1);

    // LEN=0 then a short job: no carry-over of partial sums.
    px.delete(); pw.delete();
    run_job(0, 0, -1);
    chk("t4_len0_out", cap_out, 0);
    chk("t4_len0_ovf", longint'(cap_ovf), 0);
    px = '{5, -1}; pw = '{5, 7};
    run_job(2, 0, -1);
    chk("t4_model", model_out, 18);
    chk("t4_out", cap_out, 18);

    // Result held for 10 cycles with an ignored start in between.
    px = '{7, -9, 11}; pw = '{-3, 4, 2};
    run_job(3, 10, -1);
    chk("t5_model", model_out, -35);
    chk("t5_out", cap_out, -35);

    // Reset in the middle of RUN, then a clean job.
    set_pairs(5, -128, 127);
    run_job(5, 0, 2);
    step();
    px = '{2, 4}; pw = '{3, 5};
    run_job(2, 0, -1);
    chk("t6_model", model_out, 26);
    chk("t6_out", cap_out, 26);

    // Random jobs: mixed lengths, bubbles, value ranges and hold times.
    for (int j = 0; j < 30; j++) begin
      int len;
      len = $urandom_range(12);
      if (j % 2 == 0) set_pairs(len, -128, 127);
      else set_pairs(len, -20, 20);
      pv.delete();
      for (int k = 0; k < 2 * len; k++) pv.push_back($urandom_range(3) != 0);
      run_job(len, $urandom_range(3), -1);
      if ($urandom_range(3) == 0) step();
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/macu_dot_seq.md
# macu_dot_seq

Sequencer that computes a signed dot product of a length-programmable stream of (activation, weight) pairs on a single `macu` instance. It owns all `macu` inputs and feeds `macu.co` back into `macu.ci`. Two partial sums are interleaved on even and odd issue slots so the unit accepts one pair per cycle. At the end of a job it merges the two partial sums and presents the result on a valid/ready output. It sits between the layer-level scheduler (job start and length) and the activation/weight fetch stream.

## Interface
- `DW`, 8, activation and weight width (signed); must match `macu.DW`.
- `CW`, 16, accumulator width; must match `macu.CW`. `mac_co` is CW+1 bits.
- `LW`, 10, width of the job length field.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low; shared with `macu`.
- `start`  in  1  job start pulse; ignored unless in IDLE.
- `cfg_len`  in  LW  number of pairs in the job; sampled when `start` is accepted.
- `busy`  out  1  high in every state except IDLE.
- `in_valid`  in  1  a pair is presented.
- `in_ready`  out  1  high in RUN only.
- `in_x`, `in_w`  in  DW each  signed activation and signed weight.
- `mac_xi`, `mac_wi`  out  DW each  drive `macu.xi` and `macu.wi`.
- `mac_w_en`  out  1  drives `macu.w_en`.
- `mac_ci`  out  CW  drives `macu.ci`.
- `mac_co`  in  CW+1  from `macu.co`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result accepted.
- `out_data`  out  CW+1  signed dot product.
- `ovf`  out  1  a saturation occurred in the current or last job; cleared on `start`.

## Operation
- **`macu` pipeline slot model.**
  - A slot issued in cycle t has its `xi`/`wi` sampled at edge t+1.
  - `ci` for that slot must be driven during cycle t+2.
  - The slot's `co` is visible during cycle t+4.
  - So `co` visible in cycle c belongs to slot c-4, and feeds `ci` of slot c-2. This is why same-parity slots chain through direct feedback.
- **Issue, every cycle.**
  - In RUN with `in_valid`: `mac_xi`=`in_x`, `mac_wi`=`in_w`, `mac_w_en`=1, the pair is accepted and `cnt` increments.
  - Otherwise (bubble): `mac_xi`=0, `mac_w_en`=0, `mac_wi`=0. The product is 0 and the slot parity rhythm is kept.
- **Feedback.**
  - `fb` = (state==RUN) delayed 2 cycles.
  - `mac_ci` = `fb` ? sat_CW(`mac_co`) : 0.
  - sat_CW clamps to [-2^(CW-1), 2^(CW-1)-1]. Any clamp sets `ovf`.
  - Every non-RUN slot therefore carries ci=0 and x=0, and yields co=0. This guarantees zero initial partial sums for the next job.
- **FSM.**
  - IDLE: on `start`, `cnt`←0, `len`←`cfg_len`, `ovf`←0. Go to RUN if `cfg_len`≠0, else go to DRAIN.
  - RUN: go to DRAIN in the cycle after the pair that makes `cnt`==`len` is accepted.
  - DRAIN: 4 cycles, d0..d3, counted by `dcnt`.
    - At d2: `psum_a`←sat_CW(`mac_co`).
    - At d3: `out_data`←sext(`psum_a`)+sext(sat_CW(`mac_co`)). This is exact in CW+1 bits. Then go to OUT.
  - OUT: `out_valid`=1 and `out_data` is held until `out_ready`, then go to IDLE.
- **Boundary cases.**
  - `start` while busy: ignored.
  - `in_valid` outside RUN: not accepted.
  - LEN=1: the partner partial sum comes from an idle slot and equals 0.
  - LEN=0: `out_data`=0, `ovf`=0.
- **Reset mid-job:** everything returns to reset values, the job is discarded, and `macu` clears through the shared `rst_n`.
- **Reset values:** state IDLE; `busy`, `in_ready`, `out_valid`, `ovf` = 0; `out_data`, `mac_xi`, `mac_wi`, `mac_ci` = 0; `mac_w_en`=0.

## Timing
- Throughput: 1 pair per cycle while `in_valid` is held.
- Last pair accepted in cycle T-1 → DRAIN occupies T..T+3 → `out_valid` rises in cycle T+4.
- LEN pairs with no bubbles: `start` at cycle s gives `out_valid` at s+LEN+5.
- Minimum gap between jobs: 1 cycle in IDLE.
- Issue outputs are combinational from the state and `in_valid`. `mac_ci` is combinational from `mac_co`, with no additional register, to meet the 2-slot feedback.

## Structure
- Shared package `macu_pkg`:
  - FSM state enum (IDLE, RUN, DRAIN, OUT).
  - Default values for DW/CW.
  - The saturation function sat_CW.
- One natural sub-module: `macu`, instantiated inside `macu_dot_seq`, so the top-level user sees only the stream and result interfaces. The `mac_*` ports then become internal nets. Keep them observable for the bench.

## Test plan
- LEN=1, x=3, w=-4, `in_valid` high → `out_data`=-12 exactly 5 cycles after acceptance, `ovf`=0.
- LEN=4, pairs (1,1),(2,2),(3,3),(4,4) with `in_valid` low for 2 cycles after the second pair → `out_data`=30, and bubbles show `mac_w_en`=0.
- LEN=6, all pairs x=-128, w=-128 → feedback clamps at 32767 in both parities, `out_data`=65534, `ovf`=1.
- LEN=0 → `out_data`=0 after DRAIN. A following LEN=2 job with (5,5),(-1,7) → 18, showing no carry-over of partial sums.
- `out_ready` held low 10 cycles → `out_valid`/`out_data` stable. A `start` during that time is ignored, and `in_ready` stays 0.
- `rst_n` asserted mid-RUN, then a new LEN=2 job (2,3),(4,5) → 26, with all outputs at reset values while `rst_n` is low.
